sram_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data SRAM (combinational read, write on rising `clk`) between the processor's memory path (port 0) and a program-loader/DMA engine (port 1). It sits between both requesters and the SRAM, muxes address/data/write from the granted port, and returns registered read data with a one-cycle valid pulse. Grants are round-robin with a bounded burst length, so neither side can starve the other.

---
 rtl/arb_pkg.sv | 15 +
 rtl/arb_burst_counter.sv | 32 +++
 rtl/sram_port_arbiter.sv | 131 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package arb_pkg;

    // Arbiter ownership states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Port indices, also the encoding of the last-granted port.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/arb_burst_counter.sv
// Saturating per-grant access counter; flags the access that uses up the burst.
module arb_burst_counter #(
    parameter int MAX_BURST = 4,
    localparam int BW = $clog2(MAX_BURST + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [BW-1:0] count,
    output logic          limit_reached
);

    localparam logic [BW-1:0] ONE = 1;

    // High when an access in this cycle would complete (or exceed) the burst.
    // Using >= rather than == keeps a saturated counter yielding at once
    // when a competitor shows up after a long uncontested run.
    assign limit_reached = (int'(count) + 1) >= MAX_BURST;

    // Clear on grant change, otherwise count accesses up to MAX_BURST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (int'(count) < MAX_BURST)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin, burst-limited arbiter sharing one single-port SRAM between
// the CPU memory path (port 0) and the loader/DMA engine (port 1).
// Handshake: a port's access happens in every cycle where its req and gnt
// are both high; addr/we/wdata are taken from that port in that cycle and
// a read returns rdata with a one-cycle rvalid pulse in the next cycle.
module sram_port_arbiter
    import arb_pkg::*;
#(
    parameter int word_size = 8,
    parameter int MAX_BURST = 4,
    localparam int BW = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [word_size-1:0] addr0,
    input  logic [word_size-1:0] addr1,
    input  logic [word_size-1:0] wdata0,
    input  logic [word_size-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic [word_size-1:0] rdata,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [word_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_wdata,
    output logic                 mem_write,
    input  logic [word_size-1:0] mem_rdata,
    output logic [1:0]           state,
    output logic [BW-1:0]        bcnt
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last;
    logic       access0;
    logic       access1;
    logic       limit_reached;
    logic       grant_change;

    assign gnt0         = (state_q == OWN0);
    assign gnt1         = (state_q == OWN1);
    assign state        = state_q;
    assign grant_change = (state_d != state_q);

    // An access is a granted port that is also requesting.
    always_comb begin
        access0 = gnt0 && req0;
        access1 = gnt1 && req1;
    end

    // SRAM mux: drive from the accessing port, all zero otherwise.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        if (access0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_write = we0;
        end else if (access1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_write = we1;
        end
    end

    // Next grant: round-robin from IDLE, hand over on release or burst end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1)  state_d = (last == PORT_LDR) ? OWN0 : OWN1;
                else if (req0)     state_d = OWN0;
                else if (req1)     state_d = OWN1;
                else               state_d = IDLE;
            end
            OWN0: begin
                if (!req0)                      state_d = req1 ? OWN1 : IDLE;
                else if (req1 && limit_reached) state_d = OWN1;
                else                            state_d = OWN0;
            end
            OWN1: begin
                if (!req1)                      state_d = req0 ? OWN0 : IDLE;
                else if (req0 && limit_reached) state_d = OWN0;
                else                            state_d = OWN1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant register and record of the most recently granted port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last    <= PORT_LDR;
        end else begin
            state_q <= state_d;
            if (state_d == OWN0 && grant_change) last <= PORT_CPU;
            if (state_d == OWN1 && grant_change) last <= PORT_LDR;
        end
    end

    // Capture read data and raise the owning port's rvalid for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= access0 && !we0;
            rvalid1 <= access1 && !we1;
            if ((access0 && !we0) || (access1 && !we1)) rdata <= mem_rdata;
        end
    end

    arb_burst_counter #(
        .MAX_BURST(MAX_BURST)
    ) u_burst (
        .clk          (clk),
        .rst          (rst),
        .clr          (grant_change),
        .inc          (access0 || access1),
        .count        (bcnt),
        .limit_reached(limit_reached)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM model, directed scenarios and a read
// scoreboard keyed on port and expected data.
module tb_sram_port_arbiter;
    import arb_pkg::*;

    localparam int W  = 8;
    localparam int MB = 4;
    localparam int BW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [W-1:0]  addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_write;
    logic [W-1:0]  rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]    state;
    logic [BW-1:0] bcnt;

    logic [W-1:0]  sram    [256];
    logic [W-1:0]  ref_mem [256];
    logic [W:0]    exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            wr_cycles = 0;
    logic          g0_log [13];
    logic          g1_log [13];

    sram_port_arbiter #(.word_size(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .state(state), .bcnt(bcnt)
    );

    // Clock and SRAM model.
    always #5 clk = ~clk;
    assign mem_rdata = sram[mem_addr];
    always @(posedge clk) if (mem_write) sram[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference memory follows the requesters' own writes.
    always @(posedge clk) begin
        if (!rst && gnt0 && req0 && we0) ref_mem[addr0] <= wdata0;
        if (!rst && gnt1 && req1 && we1) ref_mem[addr1] <= wdata1;
    end

    // Monitor: SRAM mux checks, scoreboard pop, then push of new reads.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt0 && gnt1) check("one_hot_gnt", 1, 0);
            if (mem_write) wr_cycles++;
            if (rvalid0 || rvalid1) begin
                if (exp_q.size() == 0) check("rvalid_unexpected", {31'd0, rvalid1}, 32'hFFFF);
                else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    check("rvalid_port", {30'd0, rvalid1, rvalid0}, e[W] ? 32'd2 : 32'd1);
                    check("rdata", 32'(rdata), 32'(e[W-1:0]));
                end
            end
            if (gnt0 && req0) begin
                check("mem_addr0", 32'(mem_addr), 32'(addr0));
                check("mem_write0", 32'(mem_write), 32'(we0));
                if (we0) check("mem_wdata0", 32'(mem_wdata), 32'(wdata0));
                else exp_q.push_back({1'b0, ref_mem[addr0]});
            end else if (gnt1 && req1) begin
                check("mem_addr1", 32'(mem_addr), 32'(addr1));
                check("mem_write1", 32'(mem_write), 32'(we1));
                if (we1) check("mem_wdata1", 32'(mem_wdata), 32'(wdata1));
                else exp_q.push_back({1'b1, ref_mem[addr1]});
            end else begin
                check("idle_mem_write", 32'(mem_write), 0);
                check("idle_mem_addr", 32'(mem_addr), 0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        tick();
        @(negedge clk);
        check("rst_gnt0", 32'(gnt0), 0);
        check("rst_gnt1", 32'(gnt1), 0);
        check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_bcnt", 32'(bcnt), 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    // One access on a port: request, wait for the grant, drop req after it.
    task automatic do_access(input int port, input logic we, input logic [W-1:0] a,
                             input logic [W-1:0] d);
        int n;
        if (port == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        else           begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        n = 0;
        @(negedge clk);
        while (((port == 0) ? !gnt0 : !gnt1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("grant_timeout", 0, 1);
        tick();
        if (port == 0) req0 = 0; else req1 = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]    = 8'($urandom_range(0, 255));
            ref_mem[i] = sram[i];
        end

        // 1: single port read, one-cycle grant latency.
        do_reset();
        sram[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
        req0 = 1; we0 = 0; addr0 = 8'h10;
        @(negedge clk);
        check("t1_gnt_not_yet", 32'(gnt0), 0);
        tick();
        @(negedge clk);
        check("t1_gnt0", 32'(gnt0), 1);
        check("t1_gnt1", 32'(gnt1), 0);
        tick();
        req0 = 0;
        @(negedge clk);
        check("t1_rvalid0", 32'(rvalid0), 1);
        check("t1_rdata", 32'(rdata), 32'h A5);
        check("t1_gnt1_low", 32'(gnt1), 0);
        tick(); tick();

        // 2: simultaneous contention, bursts of MB alternating.
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        addr0 = 8'($urandom_range(0, 255)); addr1 = 8'($urandom_range(0, 255));
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            g0_log[c] = gnt0;
            g1_log[c] = gnt1;
            tick();
            if (gnt0) addr0 = 8'($urandom_range(0, 255));
            if (gnt1) addr1 = 8'($urandom_range(0, 255));
        end
        req0 = 0; req1 = 0;
        for (int c = 0; c < 13; c++) begin
            check($sformatf("t2_gnt0_c%0d", c), 32'(g0_log[c]), (c >= 1 && c <= 4) || c >= 9 ? 1 : 0);
            check($sformatf("t2_gnt1_c%0d", c), 32'(g1_log[c]), (c >= 5 && c <= 8) ? 1 : 0);
        end
        tick(); tick();

        // 3: port 1 writes, port 0 reads it back.
        do_reset();
        wr_cycles = 0;
        do_access(1, 1'b1, 8'h20, 8'h3C);
        do_access(0, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        check("t3_rvalid0", 32'(rvalid0), 1);
        check("t3_rvalid1", 32'(rvalid1), 0);
        check("t3_rdata", 32'(rdata), 32'h3C);
        tick(); tick();
        check("t3_write_cycles", 32'(wr_cycles), 1);

        // 4: uncontested run past the burst limit.
        do_reset();
        req0 = 1; we0 = 1;
        addr0 = 8'($urandom_range(0, 255)); wdata0 = 8'($urandom_range(0, 255));
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("t4_gnt0_%0d", i), 32'(gnt0), 1);
            tick();
            if (i == 9) req0 = 0;
            else begin
                addr0 = 8'($urandom_range(0, 255)); wdata0 = 8'($urandom_range(0, 255));
            end
        end
        @(negedge clk);
        check("t4_bcnt_sat", 32'(bcnt), MB);
        check("t4_mem_write_off", 32'(mem_write), 0);
        tick();
        @(negedge clk);
        check("t4_idle", 32'(state), 32'(IDLE));
        check("t4_gnt0_low", 32'(gnt0), 0);
        for (int i = 0; i < 256; i++)
            if (sram[i] !== ref_mem[i]) check($sformatf("t4_sram_%0h", i), 32'(sram[i]), 32'(ref_mem[i]));

        // 5: reset pulsed inside a write access.
        do_reset();
        sram[8'h05] = 8'h00; ref_mem[8'h05] = 8'h00;
        req0 = 1; we0 = 1; addr0 = 8'h05; wdata0 = 8'hFF;
        tick();
        @(negedge clk);
        check("t5_mem_write_on", 32'(mem_write), 1);
        #1 rst = 1'b1;
        #1;
        check("t5_gnt0", 32'(gnt0), 0);
        check("t5_mem_write", 32'(mem_write), 0);
        check("t5_mem_addr", 32'(mem_addr), 0);
        check("t5_mem_wdata", 32'(mem_wdata), 0);
        check("t5_rvalid", {30'd0, rvalid1, rvalid0}, 0);
        check("t5_rdata", 32'(rdata), 0);
        tick();
        check("t5_sram", 32'(sram[8'h05]), 0);
        req0 = 0; we0 = 0;
        tick();
        rst = 1'b0;
        exp_q.delete();

        // 6: port 1 releases early while port 0 waits.
        do_reset();
        req1 = 1; we1 = 0; addr1 = 8'($urandom_range(0, 255));
        tick();
        req0 = 1; we0 = 0; addr0 = 8'($urandom_range(0, 255));
        @(negedge clk);
        check("t6_gnt1_a", 32'(gnt1), 1);
        tick();
        addr1 = 8'($urandom_range(0, 255));
        @(negedge clk);
        check("t6_gnt1_b", 32'(gnt1), 1);
        check("t6_bcnt_1", 32'(bcnt), 1);
        tick();
        req1 = 0;
        @(negedge clk);
        check("t6_bcnt_2", 32'(bcnt), 2);
        tick();
        @(negedge clk);
        check("t6_gnt0", 32'(gnt0), 1);
        check("t6_gnt1_low", 32'(gnt1), 0);
        check("t6_bcnt_clr", 32'(bcnt), 0);
        tick();
        req0 = 0;
        tick(); tick();
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
